// File: rtl/serial_comparator_ctrl_if.sv
// Handshake and result bundle for the serial magnitude comparator.
// The master side drives operands and start; the slave side returns status and results.
interface serial_comparator_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_great_b;
  logic             a_equal_b;
  logic             a_less_b;

  modport master (
    output start, a, b,
    input  busy, done, a_great_b, a_equal_b, a_less_b
  );

  modport slave (
    input  start, a, b,
    output busy, done, a_great_b, a_equal_b, a_less_b
  );
endinterface

// File: rtl/serial_comparator_ctrl.sv
// Unsigned A/B magnitude comparator that walks 2-bit slices MSB-first.
// It stops at the first differing slice and pulses done for one cycle with a registered result.
module serial_comparator_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_comparator_ctrl_if.slave  bus
);
  localparam int NSL = WIDTH / 2;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NSL - 1);

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, w_a_next, w_b_next;
  logic [IW-1:0]    r_idx, w_idx_next;
  logic             r_gt, r_eq, r_lt;
  logic             w_gt_next, w_eq_next, w_lt_next;
  logic [1:0]       w_sa, w_sb;

  assign w_sa = r_a[{r_idx, 1'b0} +: 2];
  assign w_sb = r_b[{r_idx, 1'b0} +: 2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= IDX_TOP;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_idx   <= w_idx_next;
      r_gt    <= w_gt_next;
      r_eq    <= w_eq_next;
      r_lt    <= w_lt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_idx_next   = r_idx;
    w_gt_next    = r_gt;
    w_eq_next    = r_eq;
    w_lt_next    = r_lt;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_a_next     = bus.a;
          w_b_next     = bus.b;
          w_idx_next   = IDX_TOP;
          w_state_next = S_COMPARE;
        end
      end
      S_COMPARE: begin
        // Results change only on the deciding edge so they hold across idle periods.
        if (w_sa > w_sb) begin
          {w_gt_next, w_eq_next, w_lt_next} = 3'b100;
          w_state_next = S_DONE;
        end else if (w_sa < w_sb) begin
          {w_gt_next, w_eq_next, w_lt_next} = 3'b001;
          w_state_next = S_DONE;
        end else if (r_idx == '0) begin
          {w_gt_next, w_eq_next, w_lt_next} = 3'b010;
          w_state_next = S_DONE;
        end else begin
          w_idx_next = r_idx - 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.a_great_b = r_gt;
  assign bus.a_equal_b = r_eq;
  assign bus.a_less_b  = r_lt;
endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Directed bench for serial_comparator_ctrl (WIDTH=8): results, done latency, busy, start masking and reset abort.
module tb_serial_comparator_ctrl;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  serial_comparator_ctrl_if #(.WIDTH(8)) bus ();

  serial_comparator_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] res_now();
    return {bus.a_great_b, bus.a_equal_b, bus.a_less_b};
  endfunction

  // Launch one compare; exp_res is {gt,eq,lt}; exp_lat counts edges from accept to the edge that sees done.
  task automatic run_cmp(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic [2:0] exp_res, input int exp_lat);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = va;
    bus.b     = vb;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check({tag, " busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.done) break;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " result"}, 32'(res_now()), 32'(exp_res));
    $display("[TB] %s a=%02h b=%02h lat=%0d res=%03b", tag, va, vb, n, res_now());
    @(negedge clk);
    check({tag, " done_once"}, 32'({bus.done, bus.busy}), 32'd0);
    check({tag, " hold"}, 32'(res_now()), 32'(exp_res));
  endtask

  // Independent reference: result from integer compare, latency from first differing pair.
  task automatic run_model(input logic [7:0] va, input logic [7:0] vb);
    logic [2:0] er;
    int         k;
    er = (va > vb) ? 3'b100 : ((va < vb) ? 3'b001 : 3'b010);
    k = 0;
    for (int i = 3; i >= 0; i--) begin
      k++;
      if (((va >> (2 * i)) & 8'h3) != ((vb >> (2 * i)) & 8'h3)) break;
    end
    run_cmp("model", va, vb, er, k + 1);
  endtask

  initial begin
    int n;
    int dones;
    n_tests   = 0;
    n_fail    = 0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    #1;
    check("reset outputs", 32'({bus.busy, bus.done, res_now()}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_cmp("eq_A5",  8'hA5, 8'hA5, 3'b010, 5);
    run_cmp("gt_80",  8'h80, 8'h7F, 3'b100, 2);
    run_cmp("lt_12",  8'h12, 8'h13, 3'b001, 5);
    run_cmp("eq_00",  8'h00, 8'h00, 3'b010, 5);
    run_cmp("gt_FF",  8'hFF, 8'h00, 3'b100, 2);
    run_cmp("lt_34",  8'h34, 8'h38, 3'b001, 4);
    run_cmp("gt_0C",  8'h0C, 8'h08, 3'b100, 4);

    // start and operand changes while busy must not relaunch or alter the result
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h00; bus.b = 8'hFF;
    @(posedge clk);
    #1 bus.a = 8'hFF; bus.b = 8'h00;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.done) break;
    end
    bus.start = 1'b0;
    check("ignore_start latency", 32'(n), 32'd2);
    check("ignore_start result", 32'(res_now()), 32'(3'b001));
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("ignore_start no_relaunch", 32'(dones), 32'd0);
    $display("[TB] ignore_start lat=%0d res=%03b extra_dones=%0d", n, res_now(), dones);

    // asynchronous reset mid-compare
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hA5; bus.b = 8'hA5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset outputs", 32'({bus.busy, bus.done, res_now()}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    check("async_reset no_done", 32'(dones), 32'd0);
    $display("[TB] async_reset aborted, activity after release=%0d", dones);
    run_cmp("post_reset_40", 8'h40, 8'h3F, 3'b100, 2);

    for (int t = 0; t < 24; t++) run_model(8'($urandom), 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
